serializer128: RTL and testbench
================================

Name: serializer128

Overview:
- Consumer side of the 128-bit capture stage: takes a 128-bit word offered on a valid/ready interface and streams it out as OUT_W-bit beats over a downstream valid/ready handshake.
- Sits between the 128-bit latch/capture register and narrower datapath consumers such as the 32-bit weight/activation bus.
- Emits beats LSB-first and flags the final beat of each word.

Parameters:
- OUT_W, 32, beat width in bits. Must divide 128 exactly; legal values 8, 16, 32, 64.
- BEATS, 128/OUT_W, derived local parameter; number of beats per word, always >= 2.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- clear_i  in  1  synchronous flush; drops any word in progress
- d_i  in  128  input word
- valid_i  in  1  input word valid
- ready_o  out  1  block can accept d_i this cycle
- beat_o  out  OUT_W  current output beat
- beat_valid_o  out  1  beat_o valid
- beat_ready_i  in  1  downstream accepts beat this cycle
- beat_last_o  out  1  current beat is the last beat of its word
- beat_idx_o  out  $clog2(BEATS)  index of current beat within its word
- busy_o  out  1  a word is being serialized

Behaviour:
- Reset: resetn is asynchronous, active-low; clock is clk.
- Values held in reset: state=IDLE, shift register=0, cnt=0, ready_o=1, beat_o=0, beat_valid_o=0, beat_last_o=0, beat_idx_o=0, busy_o=0.
- State machine: two states, IDLE and SEND.
- IDLE:
  - ready_o=1, beat_valid_o=0.
  - If valid_i&&ready_o: load sreg<=d_i, cnt<=0, go to SEND.
- SEND:
  - ready_o=0 (non-prefetch build), beat_valid_o=1, busy_o=1.
  - beat_o=sreg[OUT_W-1:0], beat_idx_o=cnt, beat_last_o=(cnt==BEATS-1).
  - On beat_valid_o&&beat_ready_i: sreg<=sreg>>OUT_W (zero fill), cnt<=cnt+1.
  - If the accepted beat has cnt==BEATS-1: return to IDLE, cnt<=0.
- Latency: first beat is valid exactly 1 cycle after the input handshake.
- Throughput: a full word takes BEATS cycles under continuous beat_ready_i. Without prefetch there is one idle cycle between consecutive words, so a word costs BEATS+1 cycles.
- Stability: while beat_valid_o=1 and beat_ready_i=0, beat_o, beat_idx_o and beat_last_o hold stable. beat_valid_o never drops before the beat handshake completes.
- Input data: d_i is sampled only on the handshake cycle; changes at other times are ignored. valid_i while ready_o=0 has no effect, and the upstream holds the word.
- clear_i (synchronous):
  - Next state IDLE; sreg, cnt and any prefetch holding register zeroed.
  - Takes priority over a simultaneous input handshake (that word is discarded) and over a simultaneous beat handshake.
  - ready_o is combinational from state, so it may be high during a clear cycle; a word accepted in that cycle is discarded.
- Reset mid-word: asserting resetn low during SEND immediately forces all outputs to their reset values. The partial word is lost.
- cnt counts 0..BEATS-1 and never wraps past BEATS-1.

Optional Feature:
- Macro: SERIALIZER128_PREFETCH_EN
- Defined: adds a 128-bit holding register pend plus a pend_v flag.
  - ready_o = !pend_v in every state.
  - In SEND, an input handshake writes pend and sets pend_v.
  - When the last beat is accepted and pend_v=1: sreg<=pend, pend_v<=0, cnt<=0, stay in SEND, giving gapless back-to-back words.
  - If the last beat is accepted with pend_v=0 and an input handshake in the same cycle: d_i loads straight into sreg and the block stays in SEND.
  - In IDLE, an input handshake loads sreg directly.
  - busy_o = (state==SEND) || pend_v.
  - clear_i also clears pend_v.
- Not defined: no holding register. ready_o=(state==IDLE); behaviour exactly as described above.

Test Plan:
- Single word, OUT_W=32, d_i=128'h44444444_33333333_22222222_11111111, beat_ready_i=1 -> one cycle after the handshake, beats 11111111, 22222222, 33333333, 44444444 on consecutive cycles with idx 0..3; beat_last_o only on 44444444; ready_o=1 again on the following cycle.
- Backpressure: beat_ready_i=0 for 3 cycles on beat idx 1 -> beat_o=22222222 and beat_valid_o=1 held all 3 cycles; no beat lost or duplicated; total 7 cycles from first beat to IDLE.
- clear_i asserted while beat idx 2 is pending, with valid_i=1 in the same cycle -> next cycle state IDLE, beat_valid_o=0, beat_idx_o=0; the offered word is not accepted into the serializer and is discarded; ready_o=1.
- resetn pulsed low mid-word -> beat_valid_o, beat_o and busy_o go to 0 asynchronously; after release the first word accepted serializes from idx 0.
- Back-to-back words A and B with valid_i held high and beat_ready_i=1:
  - Without SERIALIZER128_PREFETCH_EN: a 1-cycle gap with beat_valid_o=0 between A's last beat and B's first beat.
  - With SERIALIZER128_PREFETCH_EN: zero gap; 8 consecutive beats with beat_last_o asserted on beats 3 and 7.

Source files
------------

// File: rtl/serializer128.sv
// serializer128: accepts a 128-bit word on a valid/ready handshake and streams
// it out LSB-first as OUT_W-bit beats on a downstream valid/ready handshake.
// Optional build macro: SERIALIZER128_PREFETCH_EN adds a one-word holding
// register so back-to-back words stream without an idle cycle between them.
//
// Ports:
//   clk, resetn    clock, asynchronous active-low reset
//   clear_i        synchronous flush, drops any word in progress
//   d_i, valid_i   input word and its valid
//   ready_o        block can accept d_i this cycle
//   beat_o         current output beat
//   beat_valid_o   beat_o valid
//   beat_ready_i   downstream accepts the beat this cycle
//   beat_last_o    current beat is the last beat of its word
//   beat_idx_o     index of the current beat within its word
//   busy_o         a word is being serialized (or held, with prefetch)
module serializer128 #(
  parameter int unsigned OUT_W = 32
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            clear_i,
  input  logic [127:0]                    d_i,
  input  logic                            valid_i,
  output logic                            ready_o,
  output logic [OUT_W-1:0]                beat_o,
  output logic                            beat_valid_o,
  input  logic                            beat_ready_i,
  output logic                            beat_last_o,
  output logic [$clog2(128/OUT_W)-1:0]    beat_idx_o,
  output logic                            busy_o
);

  localparam int unsigned WORD_W = 128;
  localparam int unsigned BEATS  = WORD_W / OUT_W;
  localparam int unsigned IDX_W  = $clog2(BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] sreg, sreg_nxt;
  logic [IDX_W-1:0]  cnt, cnt_nxt;
`ifdef SERIALIZER128_PREFETCH_EN
  logic [WORD_W-1:0] pend, pend_nxt;
  logic              pend_v, pend_v_nxt;
`endif

  logic in_hs;
  logic beat_hs;
  logic at_last;

  assign in_hs   = valid_i && ready_o;
  assign beat_hs = beat_valid_o && beat_ready_i;
  assign at_last = (cnt == LAST_IDX);

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
`ifdef SERIALIZER128_PREFETCH_EN
      pend   <= '0;
      pend_v <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      sreg   <= sreg_nxt;
      cnt    <= cnt_nxt;
`ifdef SERIALIZER128_PREFETCH_EN
      pend   <= pend_nxt;
      pend_v <= pend_v_nxt;
`endif
    end
  end

  // Next state and datapath; clear overrides both handshakes
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
`ifdef SERIALIZER128_PREFETCH_EN
    pend_nxt   = pend;
    pend_v_nxt = pend_v;
`endif
    if (clear_i) begin
      state_nxt = IDLE;
      sreg_nxt  = '0;
      cnt_nxt   = '0;
`ifdef SERIALIZER128_PREFETCH_EN
      pend_nxt   = '0;
      pend_v_nxt = 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_hs) begin
            sreg_nxt  = d_i;
            cnt_nxt   = '0;
            state_nxt = SEND;
          end
        end
        SEND: begin
`ifdef SERIALIZER128_PREFETCH_EN
          if (in_hs) begin
            pend_nxt   = d_i;
            pend_v_nxt = 1'b1;
          end
`endif
          if (beat_hs) begin
            if (at_last) begin
              cnt_nxt = '0;
`ifdef SERIALIZER128_PREFETCH_EN
              if (pend_v) begin
                // Held word follows immediately; ready_o was low so no new word
                sreg_nxt   = pend;
                pend_v_nxt = 1'b0;
              end else if (in_hs) begin
                // Word arriving on the last beat bypasses the holding register
                sreg_nxt   = d_i;
                pend_v_nxt = 1'b0;
              end else begin
                sreg_nxt  = '0;
                state_nxt = IDLE;
              end
`else
              sreg_nxt  = '0;
              state_nxt = IDLE;
`endif
            end else begin
              sreg_nxt = sreg >> OUT_W;
              cnt_nxt  = cnt + IDX_W'(1);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    beat_valid_o = (state == SEND);
    beat_o       = (state == SEND) ? sreg[OUT_W-1:0] : '0;
    beat_idx_o   = cnt;
    beat_last_o  = (state == SEND) && at_last;
`ifdef SERIALIZER128_PREFETCH_EN
    ready_o      = !pend_v;
    busy_o       = (state == SEND) || pend_v;
`else
    ready_o      = (state == IDLE);
    busy_o       = (state == SEND);
`endif
  end

endmodule

// File: tb/tb_serializer128.sv
// Directed bench for serializer128 (OUT_W=32) with a beat scoreboard: every
// accepted input word pushes its expected beats, every accepted output beat
// pops and compares one.
module tb_serializer128;

  localparam int unsigned OUT_W = 32;
  localparam int unsigned BEATS = 128 / OUT_W;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  idx;
    logic        last;
  } beat_t;

  logic         clk;
  logic         resetn;
  logic         clear_i;
  logic [127:0] d_i;
  logic         valid_i;
  logic         ready_o;
  logic [31:0]  beat_o;
  logic         beat_valid_o;
  logic         beat_ready_i;
  logic         beat_last_o;
  logic [1:0]   beat_idx_o;
  logic         busy_o;

  beat_t sb[$];
  int n_pass  = 0;
  int n_tot   = 0;
  int n_fail  = 0;
  int n_hs    = 0;
  int n_words = 0;

  serializer128 #(.OUT_W(OUT_W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .clear_i      (clear_i),
    .d_i          (d_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .beat_o       (beat_o),
    .beat_valid_o (beat_valid_o),
    .beat_ready_i (beat_ready_i),
    .beat_last_o  (beat_last_o),
    .beat_idx_o   (beat_idx_o),
    .busy_o       (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then advance to just after the edge
  task automatic tick();
    beat_t e;
    @(negedge clk);
    if (clear_i) begin
      sb.delete();
    end else begin
      if (beat_valid_o && beat_ready_i) begin
        n_hs++;
        chk("sb_has_beat", 128'(sb.size() != 0), 128'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("beat_data", 128'(beat_o), 128'(e.data));
          chk("beat_idx",  128'(beat_idx_o), 128'(e.idx));
          chk("beat_last", 128'(beat_last_o), 128'(e.last));
        end
      end
      if (valid_i && ready_o) begin
        n_words++;
        for (int b = 0; b < BEATS; b++) begin
          e.data = d_i[b*OUT_W +: OUT_W];
          e.idx  = 2'(b);
          e.last = (b == BEATS - 1);
          sb.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 128'(beat_valid_o), 128'(0));
    chk({tag, "_ready"}, 128'(ready_o), 128'(1));
    chk({tag, "_busy"},  128'(busy_o), 128'(0));
    chk({tag, "_idx"},   128'(beat_idx_o), 128'(0));
  endtask

  localparam logic [127:0] W1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] W2 = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
  localparam logic [127:0] W3 = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
  localparam logic [127:0] W4 = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;
  localparam logic [127:0] W5 = 128'h55555555_66666666_77777777_88888888;
  localparam logic [127:0] W6 = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;
  localparam logic [127:0] WA = 128'h000000A3_000000A2_000000A1_000000A0;
  localparam logic [127:0] WB = 128'h000000B3_000000B2_000000B1_000000B0;

`ifdef SERIALIZER128_PREFETCH_EN
  localparam logic       SEND_READY = 1'b1;
  localparam logic [8:0] B2B_TRACE  = 9'b011111111;
`else
  localparam logic       SEND_READY = 1'b0;
  localparam logic [8:0] B2B_TRACE  = 9'b111101111;
`endif

  initial begin
    int hs0;
    logic [8:0] trace;

    resetn       = 1'b0;
    clear_i      = 1'b0;
    d_i          = '0;
    valid_i      = 1'b0;
    beat_ready_i = 1'b0;

    // Reset values
    #3;
    chk("rst_ready", 128'(ready_o), 128'(1));
    chk("rst_valid", 128'(beat_valid_o), 128'(0));
    chk("rst_beat",  128'(beat_o), 128'(0));
    chk("rst_idx",   128'(beat_idx_o), 128'(0));
    chk("rst_last",  128'(beat_last_o), 128'(0));
    chk("rst_busy",  128'(busy_o), 128'(0));
    #9 resetn = 1'b1;
    @(posedge clk);
    #1;

    // Single word, continuous ready
    d_i = W1; valid_i = 1'b1; beat_ready_i = 1'b1;
    tick();
    valid_i = 1'b0; d_i = {$urandom, $urandom, $urandom, $urandom};
    chk("t1_lat_valid", 128'(beat_valid_o), 128'(1));
    chk("t1_busy",      128'(busy_o), 128'(1));
    chk("t1_ready",     128'(ready_o), 128'(SEND_READY));
    hs0 = n_hs;
    repeat (4) tick();
    chk("t1_beats", 128'(n_hs - hs0), 128'(4));
    chk_idle("t1_done");
    chk("t1_sb_empty", 128'(sb.size()), 128'(0));

    // Backpressure on beat 1 for three cycles
    d_i = W2; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    hs0 = n_hs;
    tick();
    beat_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_beat",  128'(beat_o), 128'(W2[63:32]));
      chk("t2_hold_idx",   128'(beat_idx_o), 128'(1));
      chk("t2_hold_valid", 128'(beat_valid_o), 128'(1));
      tick();
    end
    beat_ready_i = 1'b1;
    repeat (3) tick();
    chk("t2_beats", 128'(n_hs - hs0), 128'(4));
    chk_idle("t2_done");
    chk("t2_sb_empty", 128'(sb.size()), 128'(0));

    // Clear while beat 2 pends, with a word offered in the same cycle
    d_i = W3; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    repeat (2) tick();
    chk("t3_pend_idx", 128'(beat_idx_o), 128'(2));
    beat_ready_i = 1'b0; clear_i = 1'b1; valid_i = 1'b1; d_i = W4;
    tick();
    clear_i = 1'b0; valid_i = 1'b0; beat_ready_i = 1'b1;
    chk_idle("t3_clr");
    hs0 = n_hs;
    repeat (3) tick();
    chk("t3_no_beats", 128'(n_hs - hs0), 128'(0));

    // Asynchronous reset in the middle of a word
    d_i = W5; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
    #3 resetn = 1'b0;
    #1;
    chk("t4_rst_valid", 128'(beat_valid_o), 128'(0));
    chk("t4_rst_beat",  128'(beat_o), 128'(0));
    chk("t4_rst_busy",  128'(busy_o), 128'(0));
    chk("t4_rst_ready", 128'(ready_o), 128'(1));
    sb.delete();
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;
    d_i = W6; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("t4_first_idx",  128'(beat_idx_o), 128'(0));
    chk("t4_first_beat", 128'(beat_o), 128'(W6[31:0]));
    hs0 = n_hs;
    repeat (4) tick();
    chk("t4_beats", 128'(n_hs - hs0), 128'(4));
    chk_idle("t4_done");

    // Back-to-back words with valid held high
    n_words = 0;
    trace = '0;
    valid_i = 1'b1; d_i = WA;
    tick();
    for (int i = 0; i < 9; i++) begin
      valid_i = (n_words < 2);
      d_i     = (n_words == 0) ? WA : WB;
      trace[i] = beat_valid_o;
      tick();
    end
    valid_i = 1'b0;
    chk("t5_words", 128'(n_words), 128'(2));
    chk("t5_trace", 128'(trace), 128'(B2B_TRACE));
    chk("t5_sb_empty", 128'(sb.size()), 128'(0));
    repeat (2) tick();
    chk_idle("t5_done");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
